// File: rtl/ewb_pmem_scheduler_if.sv
// ewb_pmem_scheduler_if
//   Groups the L2 read-miss port, the eviction write buffer port and the
//   physical-memory port around the scheduler.
//   master: scheduler view (drives l2_rdata/l2_resp, ewb_drained, pmem strobes,
//           pmem_address, pmem_wdata).
//   slave : environment view (L2, EWB and physical memory).
interface ewb_pmem_scheduler_if;
    logic         l2_read;
    logic [15:0]  l2_raddress;
    logic [127:0] l2_rdata;
    logic         l2_resp;

    logic         ewb_valid;
    logic [15:0]  ewb_address;
    logic [127:0] ewb_wdata;
    logic         ewb_drained;

    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport master (
        input  l2_read, l2_raddress, ewb_valid, ewb_address, ewb_wdata,
               pmem_rdata, pmem_resp,
        output l2_rdata, l2_resp, ewb_drained, pmem_read, pmem_write,
               pmem_address, pmem_wdata
    );

    modport slave (
        output l2_read, l2_raddress, ewb_valid, ewb_address, ewb_wdata,
               pmem_rdata, pmem_resp,
        input  l2_rdata, l2_resp, ewb_drained, pmem_read, pmem_write,
               pmem_address, pmem_wdata
    );
endinterface

// File: rtl/ewb_pmem_scheduler.sv
// ewb_pmem_scheduler
//   Arbitrates the single physical-memory port between L2 read misses and the
//   eviction write buffer drain. Reads are favoured; a drain is forced first
//   when the read targets the buffered dirty line, or after STARVE_LIMIT reads
//   have bypassed a pending writeback.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset
//     bus   - master modport carrying the L2, EWB and pmem signals
module ewb_pmem_scheduler #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ewb_pmem_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t       state;
    logic [15:0]  addr_q;
    logic [127:0] data_q;
    logic [3:0]   starve_cnt;
    logic         rd_q;
    logic         wr_q;

    logic hit;
    logic starved;
    logic go_read;
    logic go_write;

    assign hit     = (bus.l2_raddress[15:4] == bus.ewb_address[15:4]);
    assign starved = bus.ewb_valid && (starve_cnt == LIMIT);

    // IDLE priority: hazard drain, starvation drain, read, idle drain.
    always_comb begin
        go_read  = 1'b0;
        go_write = 1'b0;
        if ((bus.l2_read && bus.ewb_valid && hit) || starved) begin
            go_write = 1'b1;
        end else if (bus.l2_read) begin
            go_read = 1'b1;
        end else if (bus.ewb_valid) begin
            go_write = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            starve_cnt <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.ewb_valid) begin
                        starve_cnt <= '0;
                    end
                    if (go_write) begin
                        state  <= WRITE;
                        wr_q   <= 1'b1;
                        addr_q <= bus.ewb_address;
                        data_q <= bus.ewb_wdata;
                    end else if (go_read) begin
                        state  <= READ;
                        rd_q   <= 1'b1;
                        addr_q <= bus.l2_raddress;
                    end
                end
                READ: begin
                    if (bus.pmem_resp) begin
                        state <= IDLE;
                        rd_q  <= 1'b0;
                        // Only reads that bypass a pending writeback count.
                        if (bus.ewb_valid && (starve_cnt != LIMIT)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.pmem_resp) begin
                        state      <= IDLE;
                        wr_q       <= 1'b0;
                        starve_cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    rd_q  <= 1'b0;
                    wr_q  <= 1'b0;
                end
            endcase
        end
    end

    // Strobes come straight from state flops; responses are Mealy on pmem_resp.
    assign bus.pmem_read    = rd_q;
    assign bus.pmem_write   = wr_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = data_q;
    assign bus.l2_resp      = rd_q && bus.pmem_resp;
    assign bus.l2_rdata     = bus.l2_resp ? bus.pmem_rdata : '0;
    assign bus.ewb_drained  = wr_q && bus.pmem_resp;
endmodule

// File: doc/ewb_pmem_scheduler.md
# ewb_pmem_scheduler

Sequences the single physical-memory port between L2 read misses and the eviction write buffer (EWB) drain. It grants one pmem transaction at a time and favours L2 reads for latency. It forces a drain before any read whose line matches the buffered dirty line, and after a bounded run of reads that bypassed a pending writeback. It sits between the L2 cache, the EWB, and physical memory, and replaces direct L2/EWB connections to pmem.

## Interface
- STARVE_LIMIT, 4: number of consecutive completed reads, taken while the EWB is valid, after which a drain is forced (1..15).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- l2_read  in  1  L2 read-miss request; held until l2_resp.
- l2_raddress  in  16  L2 read address (lc3b_word); bits [15:4] are the line.
- l2_rdata  out  128  read line (lc3b_pmem_data), valid when l2_resp=1.
- l2_resp  out  1  read complete, one-cycle pulse.
- ewb_valid  in  1  EWB holds a dirty line awaiting writeback.
- ewb_address  in  16  buffered line address.
- ewb_wdata  in  128  buffered line data.
- ewb_drained  out  1  writeback complete, one-cycle pulse; EWB clears on it.
- pmem_read  out  1  pmem read strobe.
- pmem_write  out  1  pmem write strobe.
- pmem_address  out  16  pmem address.
- pmem_wdata  out  128  pmem write data.
- pmem_rdata  in  128  pmem read data.
- pmem_resp  in  1  pmem transaction complete.

## Operation
- FSM states are IDLE, READ and WRITE. Reset state is IDLE.
- Line match is defined as hit = (l2_raddress[15:4] == ewb_address[15:4]).
- IDLE priority is evaluated every cycle, first match wins:
  - l2_read & ewb_valid & hit -> WRITE (hazard drain).
  - ewb_valid & starve_cnt == STARVE_LIMIT -> WRITE.
  - l2_read -> READ.
  - ewb_valid -> WRITE (idle drain).
  - Otherwise stay in IDLE.
- On leaving IDLE, the block latches into addr_q:
  - l2_raddress when entering READ.
  - ewb_address, plus ewb_wdata into data_q, when entering WRITE.
- READ state:
  - pmem_read=1, pmem_address=addr_q.
  - On pmem_resp: l2_resp=1 and l2_rdata=pmem_rdata (combinational in that cycle), then go to IDLE.
- WRITE state:
  - pmem_write=1, pmem_address=addr_q, pmem_wdata=data_q.
  - On pmem_resp: ewb_drained=1 (combinational), then go to IDLE.
- starve_cnt is a 4-bit counter:
  - +1 on READ completion if ewb_valid=1 at that edge; saturates at STARVE_LIMIT.
  - Cleared on WRITE completion.
  - Cleared when ewb_valid=0 in IDLE.
- After a hazard drain, the waiting read is issued from IDLE on the next evaluation. The EWB is then empty, so no second drain occurs.
- pmem_resp is ignored in IDLE.
- pmem_read and pmem_write are never asserted together.

## Timing
- All outputs are 0 at reset and in IDLE: pmem_read, pmem_write, l2_resp, ewb_drained. pmem_address, pmem_wdata and l2_rdata are don't-care but driven to 0 at reset.
- Reset is asynchronous:
  - Asserting rst_n=0 mid-transaction forces IDLE and drops strobes immediately.
  - starve_cnt and addr_q/data_q clear.
  - The interrupted transaction is abandoned. Requesters re-present after reset.
- Issue latency: a request sampled in IDLE at edge N puts the strobe high from edge N+1.
- Completion: l2_resp or ewb_drained is high in the same cycle as pmem_resp, and the FSM is in IDLE at the next edge.
- One mandatory IDLE cycle separates back-to-back transactions.
- pmem_address and pmem_wdata are stable, from registers, for the whole strobe duration, even if l2/EWB inputs change.
- Strobes are Moore outputs (state-decoded). Response pulses are Mealy on pmem_resp.

## Test plan
- **Plain read.** Stimulus: ewb_valid=0; l2_read with address 0x1230; pmem_resp 3 cycles after pmem_read. Required: pmem_read high for 3 cycles at 0x1230; l2_resp pulses once with l2_rdata=pmem_rdata; no pmem_write.
- **Idle drain.** Stimulus: ewb_valid=1, address 0x4560, data 0xDEAD…BEEF; no reads. Required: pmem_write at 0x4560 with that data; ewb_drained pulses once on pmem_resp.
- **Hazard.** Stimulus: ewb_address 0x8A40, and at the same time l2_read with address 0x8A4E. Required: the WRITE to 0x8A40 completes first, then after one IDLE cycle a READ of 0x8A4E; the order is checked.
- **Starvation.** Stimulus: ewb_valid=1 at non-matching 0x0100; l2_read held continuously at varying lines; STARVE_LIMIT=4. Required: exactly 4 reads, then a WRITE to 0x0100, then reads resume; starve_cnt returns to 0.
- **Reset mid-op.** Stimulus: rst_n=0 two cycles into a WRITE. Required: pmem_write drops in the same cycle with no ewb_drained; after release, the still-valid EWB is re-drained from the start.
- **Stray response.** Stimulus: pmem_resp pulses while in IDLE. Required: no l2_resp, no ewb_drained, no state change.
